// File: rtl/optimsoc.sv
// Shared system configuration type, register map and bus FSM encoding for the
// per-tile configuration register file.
package optimsoc;

   localparam int unsigned MAX_CTLIST = 1024;

   typedef struct packed {
      logic [31:0]                     NUMTILES;
      logic [31:0]                     CORES_PER_TILE;
      logic [31:0]                     GMEM_SIZE;
      logic [31:0]                     GMEM_TILE;
      logic [31:0]                     LMEM_SIZE;
      logic [31:0]                     NUMCTS;
      logic [31:0]                     TOTAL_NUM_CORES;
      logic                            USE_DEBUG;
      logic                            DEBUG_STM;
      logic                            DEBUG_CTM;
      logic [31:0]                     DEBUG_NUM_MODS;
      logic [MAX_CTLIST-1:0][15:0]     CTLIST;
   } config_t;

   localparam logic [31:0] CONFIG_VERSION = 32'h0000_0002;

   localparam logic [11:0] REG_VERSION         = 12'h000;
   localparam logic [11:0] REG_TILEID          = 12'h004;
   localparam logic [11:0] REG_NUMTILES        = 12'h008;
   localparam logic [11:0] REG_COREBASE        = 12'h00C;
   localparam logic [11:0] REG_CORES_PER_TILE  = 12'h010;
   localparam logic [11:0] REG_GMEM_SIZE       = 12'h014;
   localparam logic [11:0] REG_GMEM_TILE       = 12'h018;
   localparam logic [11:0] REG_LMEM_SIZE       = 12'h01C;
   localparam logic [11:0] REG_NUMCTS          = 12'h020;
   localparam logic [11:0] REG_TOTAL_NUM_CORES = 12'h024;
   localparam logic [11:0] REG_DEBUG           = 12'h028;
   localparam logic [11:0] REG_DEBUG_NUM_MODS  = 12'h02C;
   localparam logic [11:0] REG_CYCLE_LO        = 12'h030;
   localparam logic [11:0] REG_CYCLE_HI        = 12'h034;
   localparam logic [11:0] REG_SCRATCH         = 12'h038;

   localparam logic [11:0] CTLIST_BASE = 12'h200;

   typedef enum logic [0:0] {StIdle, StTerm} wb_state_e;

endpackage

// File: rtl/config_cycle_counter.sv
// Free-running 64-bit cycle counter with a high-word shadow captured on snap,
// so software reading LO then HI sees one coherent value.
module config_cycle_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        snap_i,
   output logic [31:0] lo_o,
   output logic [31:0] hi_shadow_o
);

   logic [63:0] cnt_q, cnt_d;
   logic [31:0] shadow_q, shadow_d;

   always_comb begin
      cnt_d    = cnt_q + 64'd1;
      shadow_d = shadow_q;
      if (snap_i) begin
         shadow_d = cnt_q[63:32];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   assign lo_o        = cnt_q[31:0];
   assign hi_shadow_o = shadow_q;

endmodule

// File: rtl/config_regfile.sv
// Wishbone B3 classic slave exposing the tile's static configuration, a cycle
// counter with atomic snapshot, and one byte-writable scratch register.
module config_regfile
   import optimsoc::*;
#(
   parameter config_t     CONFIG   = '0,
   parameter int unsigned TILEID   = 0,
   parameter int unsigned COREBASE = 0,
   parameter int unsigned MAX_CTS  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   wb_state_e   state_q, state_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] dat_q, dat_d;
   logic [31:0] scratch_q, scratch_d;

   logic        snap;
   logic [31:0] cyc_lo, cyc_hi;

   logic [11:0] adr;
   logic [9:0]  ct_word;
   logic [9:0]  ct_idx_lo, ct_idx_hi;
   logic [15:0] ct_lo, ct_hi;
   logic        ct_hit;
   logic        rd_hit;
   logic [31:0] rd_data;
   logic        unused_adr;

   assign adr        = {wb_adr_i[11:2], 2'b00};
   assign unused_adr = ^{wb_adr_i[31:12], wb_adr_i[1:0]};

   // Each CT word packs two 16-bit entries; halves past NUMCTS read as zero.
   assign ct_word   = 10'((adr - CTLIST_BASE) >> 2);
   assign ct_hit    = (adr >= CTLIST_BASE) && (ct_word < 10'(MAX_CTS / 2));
   assign ct_idx_lo = {ct_word[8:0], 1'b0};
   assign ct_idx_hi = {ct_word[8:0], 1'b1};
   assign ct_lo     = ({22'd0, ct_idx_lo} < CONFIG.NUMCTS) ? CONFIG.CTLIST[ct_idx_lo] : 16'd0;
   assign ct_hi     = ({22'd0, ct_idx_hi} < CONFIG.NUMCTS) ? CONFIG.CTLIST[ct_idx_hi] : 16'd0;

   always_comb begin
      rd_hit  = 1'b1;
      rd_data = '0;
      case (adr)
         REG_VERSION:         rd_data = CONFIG_VERSION;
         REG_TILEID:          rd_data = 32'(TILEID);
         REG_NUMTILES:        rd_data = CONFIG.NUMTILES;
         REG_COREBASE:        rd_data = 32'(COREBASE);
         REG_CORES_PER_TILE:  rd_data = CONFIG.CORES_PER_TILE;
         REG_GMEM_SIZE:       rd_data = CONFIG.GMEM_SIZE;
         REG_GMEM_TILE:       rd_data = CONFIG.GMEM_TILE;
         REG_LMEM_SIZE:       rd_data = CONFIG.LMEM_SIZE;
         REG_NUMCTS:          rd_data = CONFIG.NUMCTS;
         REG_TOTAL_NUM_CORES: rd_data = CONFIG.TOTAL_NUM_CORES;
         REG_DEBUG:           rd_data = {29'd0, CONFIG.DEBUG_CTM, CONFIG.DEBUG_STM,
                                         CONFIG.USE_DEBUG};
         REG_DEBUG_NUM_MODS:  rd_data = CONFIG.DEBUG_NUM_MODS;
         REG_CYCLE_LO:        rd_data = cyc_lo;
         REG_CYCLE_HI:        rd_data = cyc_hi;
         REG_SCRATCH:         rd_data = scratch_q;
         default: begin
            if (ct_hit) begin
               rd_data = {ct_hi, ct_lo};
            end else begin
               rd_hit = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      dat_d     = '0;
      scratch_d = scratch_q;
      snap      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (wb_cyc_i && wb_stb_i) begin
               state_d = StTerm;
               if (wb_we_i) begin
                  if (adr == REG_SCRATCH) begin
                     ack_d = 1'b1;
                     for (int b = 0; b < 4; b++) begin
                        if (wb_sel_i[b]) begin
                           scratch_d[8*b +: 8] = wb_dat_i[8*b +: 8];
                        end
                     end
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (rd_hit) begin
                  ack_d = 1'b1;
                  dat_d = rd_data;
                  snap  = (adr == REG_CYCLE_LO);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StTerm: begin
            // Termination lasts one cycle; a held strobe is re-accepted next.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_q     <= '0;
         scratch_q <= '0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         dat_q     <= dat_d;
         scratch_q <= scratch_d;
      end
   end

   config_cycle_counter u_cycle_counter (
      .clk         (clk),
      .rst         (rst),
      .snap_i      (snap),
      .lo_o        (cyc_lo),
      .hi_shadow_o (cyc_hi)
   );

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_dat_o = dat_q;

endmodule

// File: doc/config_regfile.md
# config_regfile

Memory-mapped, read-mostly register file that exposes a tile's static system configuration (tile ID, tile/core counts, memory sizes, debug setup, compute-tile list) to software over a Wishbone B3 classic slave port. It also provides a 64-bit free-running cycle counter with an atomic snapshot read and one writable scratch register. One instance sits in each compute tile's bus segment, next to the network adapter. All values derive from the tile's `config_t`.

## Interface
- `CONFIG`, default none (must be set), `optimsoc::config_t` of the system; source of all read-only fields.
- `TILEID`, default 0, tile index returned at `TILEID` register.
- `COREBASE`, default 0, global ID of core 0 in this tile.
- `MAX_CTS`, default 64, compute-tile list capacity; even, 2..1024; `CONFIG.NUMCTS <= MAX_CTS`.
- `clk` in 1, system clock.
- `rst` in 1, synchronous active-high reset.
- `wb_adr_i` in 32, byte address; bits [1:0] ignored; decode on bits [11:2].
- `wb_dat_i` in 32, write data.
- `wb_sel_i` in 4, byte enables; writes only.
- `wb_we_i` in 1, write strobe.
- `wb_cyc_i` in 1, cycle valid.
- `wb_stb_i` in 1, strobe.
- `wb_dat_o` out 32, read data; valid only while `wb_ack_o`=1, otherwise 0.
- `wb_ack_o` out 1, successful termination.
- `wb_err_o` out 1, error termination.

## Operation
- Register map (byte offsets):
  - 0x00 VERSION = 0x0000_0002.
  - 0x04 TILEID.
  - 0x08 NUMTILES.
  - 0x0C COREBASE.
  - 0x10 CORES_PER_TILE.
  - 0x14 GMEM_SIZE.
  - 0x18 GMEM_TILE.
  - 0x1C LMEM_SIZE.
  - 0x20 NUMCTS.
  - 0x24 TOTAL_NUM_CORES.
  - 0x28 DEBUG = {29'b0, DEBUG_CTM, DEBUG_STM, USE_DEBUG}.
  - 0x2C DEBUG_NUM_MODS.
  - 0x30 CYCLE_LO.
  - 0x34 CYCLE_HI.
  - 0x38 SCRATCH.
- CT list: 0x200 + 4*i, for i in 0..MAX_CTS/2-1, reads {CTLIST[2i+1], CTLIST[2i]}. Any 16-bit half whose index is >= NUMCTS reads 0.
- Cycle counter: 64 bits, reset 0, +1 every cycle, wraps 2^64-1 -> 0.
- CYCLE_LO read returns counter[31:0] sampled in the request cycle. In the same cycle, counter[63:32] is loaded into a shadow register (reset 0).
- CYCLE_HI read returns the shadow register. Software reads LO then HI to get a coherent 64-bit value.
- SCRATCH: reset 0; read/write; byte-wise write under `wb_sel_i`.
- Error cases, terminated with `wb_err_o` (no state change, `wb_dat_o`=0):
  - write to any address other than SCRATCH;
  - any access to an unmapped address (0x3C..0x1FC, or CT index >= MAX_CTS/2).

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, counter=0, shadow=0, scratch=0.
- Request = `wb_cyc_i & wb_stb_i` while no termination is being driven.
- Termination latency is exactly 1 cycle. Request seen at edge N gives `wb_ack_o` or `wb_err_o` high for exactly the cycle after edge N.
- The termination is deasserted at the next edge even if the master holds `stb`. A held request is then accepted as a new access, so back-to-back accesses terminate every second cycle.
- `wb_ack_o` and `wb_err_o` are never high together.
- SCRATCH write commits at the same edge that raises `wb_ack_o`.
- Reset during an access: termination is dropped at the reset edge and no late ack is issued. The master must restart the access.
- Counter wrap during a CYCLE_LO read: LO and shadow come from the same counter value. For example, 0x0000_0000_FFFF_FFFF gives LO=0xFFFF_FFFF and HI=0.
- `wb_cyc_i`=0 with `wb_stb_i`=1 is ignored.

## Structure
- The shared `optimsoc` package holds the register offset localparams, `CONFIG_VERSION`, and `CTLIST_BASE`=0x200.
- One sub-module: `config_cycle_counter`. It contains the 64-bit counter plus the snapshot shadow, with a `snap` input and `lo`/`hi_shadow` outputs.
- Decode and the Wishbone FSM (IDLE/TERM, 2 states) live in the top module.

## Test plan
- Reset, then read 0x00 and 0x04 with TILEID=3 -> ack one cycle later; data 0x0000_0002, then 0x3.
- CONFIG with NUMCTS=3 and CTLIST={5,7,9} -> reads:
  - 0x200 = 0x0007_0005;
  - 0x204 = 0x0000_0009;
  - 0x208 = 0.
  - 0x200+4*(MAX_CTS/2) -> err.
- Write 0xA5A5_A5A5 to SCRATCH with sel=4'b0101, then read -> 0x00A5_00A5.
- Write to 0x04 -> err, and a later read still returns TILEID. A read of 0x3C -> err.
- Force the counter to 0x0000_0001_FFFF_FFFE, read LO at that cycle, then HI after 10 cycles -> LO=0xFFFF_FFFE, HI=0x1.
- Hold `stb` high for 6 cycles -> ack pattern 0,1,0,1,0,1. Assert `rst` in an ack cycle -> ack 0 next cycle, scratch 0.
